// File: rtl/inv_subbytes_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inv_subbytes_pkg
// Brief    : Shared types and constants for the InvSubBytes scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package inv_subbytes_pkg;

  // Scheduler sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int BLOCK_BYTES = 16;
  localparam int CNT_W       = 4;

endpackage
`default_nettype wire

// File: rtl/inv_subbytes_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : inv_subbytes_sched_if
// Brief    : Requester/consumer bundle of the InvSubBytes scheduler.
//            master = requesters + result consumer, slave = scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface inv_subbytes_sched_if
  import inv_subbytes_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*8*BLOCK_BYTES-1:0] req_data;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [8*BLOCK_BYTES-1:0]         rsp_data;
  logic [ID_W-1:0]                  rsp_id;
  logic                             busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

endinterface
`default_nettype wire

// File: rtl/inv_subbytes_sched_lut.sv
`default_nettype none
// ============================================================================
// Module   : inv_sbox_lut
// Brief    : Combinational AES inverse S-box (FIPS-197 table), 8 in / 8 out.
// Revision : 1.0 - initial release
// ============================================================================
module inv_sbox_lut (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // Entry 0 sits in the most significant byte, so entry x starts at bit
  // 8*(255-x), i.e. {~x, 3'b000}.
  localparam logic [2047:0] c_inv_sbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign byte_o = c_inv_sbox[{~byte_i, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/inv_subbytes_sched.sv
`default_nettype none
// ============================================================================
// Module   : inv_subbytes_sched
// Brief    : Round-robin arbiter + byte sequencer sharing one inverse S-box
//            across NUM_REQ requesters; returns each block tagged with its id.
// Options  : INV_SUBBYTES_SCHED_PIPE_EN - registers the S-box output, adding
//            one cycle to RUN (result write lags the lookup by one cycle).
// Revision : 1.0 - initial release
// ============================================================================
module inv_subbytes_sched
  import inv_subbytes_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  inv_subbytes_sched_if.slave bus
);

  localparam int               c_blk_w    = 8 * BLOCK_BYTES;
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(BLOCK_BYTES - 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [c_blk_w-1:0] blk_q, blk_d;
  logic [c_blk_w-1:0] res_q, res_d;

  logic               w_grant_vld;
  logic [ID_W-1:0]    w_grant_id;
  logic [ID_W-1:0]    w_cand;
  logic [c_blk_w-1:0] w_req_blk;
  logic [7:0]         w_lut_out;
  logic               w_wr_en;
  logic [CNT_W-1:0]   w_wr_idx;
  logic [7:0]         w_wr_byte;

  inv_sbox_lut u_lut (
    .byte_i (blk_q[{cnt_q, 3'b000} +: 8]),
    .byte_o (w_lut_out)
  );

`ifdef INV_SUBBYTES_SCHED_PIPE_EN
  logic [7:0]       pipe_q;
  logic [CNT_W-1:0] pipe_idx_q;
  logic             pipe_vld_q;

  // Carry each lookup result with its byte index; stop after byte 15 lands
  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_q     <= '0;
      pipe_idx_q <= '0;
      pipe_vld_q <= 1'b0;
    end else begin
      pipe_q     <= w_lut_out;
      pipe_idx_q <= cnt_q;
      pipe_vld_q <= (state_q == RUN) && !(pipe_vld_q && (pipe_idx_q == c_last_idx));
    end
  end

  assign w_wr_en   = pipe_vld_q;
  assign w_wr_idx  = pipe_idx_q;
  assign w_wr_byte = pipe_q;
`else
  assign w_wr_en   = (state_q == RUN);
  assign w_wr_idx  = cnt_q;
  assign w_wr_byte = w_lut_out;
`endif

  // Round-robin search from rr_ptr+1; the nearest valid requester wins
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = (int'(rr_ptr_q) + k >= NUM_REQ) ? ID_W'(int'(rr_ptr_q) + k - NUM_REQ)
                                               : ID_W'(int'(rr_ptr_q) + k);
      if (bus.req_valid[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_cand;
      end
    end
    // No grant while idle-blocked or held in reset
    if (!rst || state_q != IDLE) begin
      w_grant_vld = 1'b0;
    end
  end

  // One-hot ready towards the granted requester and its block select
  always_comb begin
    bus.req_ready = '0;
    w_req_blk     = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (w_grant_id == ID_W'(r)) begin
        w_req_blk = bus.req_data[r*c_blk_w +: c_blk_w];
      end
    end
    if (w_grant_vld) begin
      bus.req_ready[w_grant_id] = 1'b1;
    end
  end

  // Next-state: capture on grant, stream bytes in RUN, hold result in RESP
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    res_d    = res_q;
    if (w_wr_en) begin
      res_d[{w_wr_idx, 3'b000} +: 8] = w_wr_byte;
    end
    case (state_q)
      IDLE: begin
        if (w_grant_vld) begin
          blk_d    = w_req_blk;
          id_d     = w_grant_id;
          rr_ptr_d = w_grant_id;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Leave on the write of the final byte, not on the counter wrap
        if (w_wr_en && (w_wr_idx == c_last_idx)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any block in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      id_q     <= '0;
      cnt_q    <= '0;
      blk_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      blk_q    <= blk_d;
      res_q    <= res_d;
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = res_q;
  assign bus.rsp_id    = id_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_inv_subbytes_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_subbytes_sched
// Brief    : Self-checking bench for inv_subbytes_sched. The reference
//            inverse S-box is derived from GF(2^8) arithmetic and the
//            forward affine map; arbitration is modelled as a rotating search.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_subbytes_sched;

`ifdef INV_SUBBYTES_SCHED_PIPE_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   m_ptr = 3;
  logic [7:0] inv_tab [256];

  inv_subbytes_sched_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  inv_subbytes_sched #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  // Forward S-box = affine(GF inverse); invert the mapping into inv_tab
  task automatic build_ref();
    logic [7:0] b, s;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      end
      s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_inv(input logic [127:0] d);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) o[{i[3:0], 3'b000} +: 8] = inv_tab[d[{i[3:0], 3'b000} +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int model_grant(input logic [3:0] v, input int ptr);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (ptr + k) % 4;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int g);
    return (g < 0) ? 4'b0000 : (4'b0001 << g);
  endfunction

  // Drive one block from requester r with rsp_ready high; no checking here
  task automatic serve(input int r, input logic [127:0] d, output logic [127:0] got,
                       output int gid, output int lat, output bit ok);
    int n = 0;
    ok = 1'b0; got = '0; gid = -1; lat = 0;
    bus.req_data[{r[1:0], 7'd0} +: 128] = d;
    bus.req_valid[r[1:0]] = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    while (bus.req_ready[r[1:0]] !== 1'b1 && n < 50) begin tick(); n++; end
    if (n < 50) begin
      m_ptr = r;
      tick();
      bus.req_valid[r[1:0]] = 1'b0;
      bus.req_data[{r[1:0], 7'd0} +: 128] = rand128();
      lat = 1;
      while (bus.rsp_valid !== 1'b1 && lat < 60) begin tick(); lat++; end
      if (bus.rsp_valid === 1'b1) begin
        ok = 1'b1; got = bus.rsp_data; gid = int'(bus.rsp_id);
      end
      tick();
    end else begin
      bus.req_valid[r[1:0]] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_valid = '0; bus.req_data = '0; bus.rsp_ready = 1'b0;
    tick(); tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'h0 ||
        bus.rsp_id !== 2'd0 || bus.rsp_data !== 128'h0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b rsp_valid=%b req_ready=%b rsp_id=%0d rsp_data=%h, required all zero",
               bus.busy, bus.rsp_valid, bus.req_ready, bus.rsp_id, bus.rsp_data);
    end
    rst = 1'b1;
    m_ptr = 3;
    tick();
  endtask

  task automatic test_known_vector();
    logic [127:0] d = 128'h0f0e0d0c0b0a09080706050403020100;
    logic [127:0] got; int gid, lat; bit ok;
    serve(0, d, got, gid, lat, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL kv_timeout: no response, required one"); end
    n_vec++;
    if (gid != 0) begin n_err++; $display("FAIL kv_id: got %0d required 0", gid); end
    n_vec++;
    if (got !== 128'hfbd7f3819ea340bf38a53630d56a0952) begin
      n_err++; $display("FAIL kv_data: got %h required fbd7f3819ea340bf38a53630d56a0952", got);
    end
    n_vec++;
    if (got !== ref_inv(d)) begin n_err++; $display("FAIL kv_model: got %h required %h", got, ref_inv(d)); end
    n_vec++;
    if (lat != LAT) begin n_err++; $display("FAIL kv_latency: got %0d required %0d", lat, LAT); end
  endtask

  task automatic test_const_blocks();
    logic [127:0] got; int gid, lat; bit ok;
    serve(2, {16{8'h63}}, got, gid, lat, ok);
    n_vec++;
    if (!ok || gid != 2 || got !== 128'h0) begin
      n_err++; $display("FAIL const63: ok=%0d id=%0d data=%h required id 2 data 0", ok, gid, got);
    end
    serve(3, {16{8'hff}}, got, gid, lat, ok);
    n_vec++;
    if (!ok || gid != 3 || got !== {16{8'h7d}}) begin
      n_err++; $display("FAIL constff: ok=%0d id=%0d data=%h required id 3 data %h", ok, gid, got, {16{8'h7d}});
    end
    n_vec++;
    if (lat != LAT) begin n_err++; $display("FAIL constff_latency: got %0d required %0d", lat, LAT); end
  endtask

  task automatic test_round_robin();
    logic [127:0] exp_q [$];
    int           eid_q [$];
    int nrsp = 0, cyc = 0, g, pend = -1;
    bus.rsp_ready = 1'b1;
    for (int r = 0; r < 4; r++) bus.req_data[{r[1:0], 7'd0} +: 128] = rand128();
    bus.req_valid = 4'hf;
    #1;
    while (nrsp < 8 && cyc < 400) begin
      if (pend >= 0) begin
        bus.req_data[{pend[1:0], 7'd0} +: 128] = rand128();
        pend = -1;
        #1;
      end
      if (bus.rsp_valid === 1'b1) begin
        n_vec++;
        if (eid_q.size() == 0) begin
          n_err++; $display("FAIL rr_spurious: rsp_id %0d, required no response", bus.rsp_id);
        end else begin
          if (bus.rsp_id !== 2'(eid_q[0]) || bus.rsp_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL rr_rsp: id %0d data %h, required id %0d data %h",
                     bus.rsp_id, bus.rsp_data, eid_q[0], exp_q[0]);
          end
          void'(eid_q.pop_front());
          void'(exp_q.pop_front());
        end
        nrsp++;
        if (nrsp == 8) bus.req_valid = 4'h0;
      end
      if (bus.req_ready !== 4'h0) begin
        g = model_grant(bus.req_valid, m_ptr);
        n_vec++;
        if (bus.req_ready !== onehot(g)) begin
          n_err++; $display("FAIL rr_grant: req_ready %b required %b", bus.req_ready, onehot(g));
        end
        if (g >= 0) begin
          eid_q.push_back(g);
          exp_q.push_back(ref_inv(bus.req_data[{g[1:0], 7'd0} +: 128]));
          m_ptr = g;
          pend = g;
        end
      end
      tick();
      cyc++;
    end
    bus.req_valid = 4'h0;
    n_vec++;
    if (nrsp != 8) begin n_err++; $display("FAIL rr_count: got %0d responses required 8", nrsp); end
    tick();
  endtask

  task automatic test_random_arb();
    for (int it = 0; it < 12; it++) begin
      logic [127:0] dv [4];
      logic [3:0]   m;
      int           g, n;
      m = 4'($urandom_range(1, 15));
      for (int r = 0; r < 4; r++) begin
        dv[r] = rand128();
        bus.req_data[{r[1:0], 7'd0} +: 128] = dv[r];
      end
      bus.rsp_ready = 1'b0;
      bus.req_valid = m;
      #1;
      g = model_grant(m, m_ptr);
      n_vec++;
      if (bus.req_ready !== onehot(g)) begin
        n_err++; $display("FAIL rnd_grant: mask %b req_ready %b required %b", m, bus.req_ready, onehot(g));
      end
      tick();
      bus.req_valid = 4'h0;
      m_ptr = g;
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 60) begin tick(); n++; end
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(g) || bus.rsp_data !== ref_inv(dv[g])) begin
          n_err++;
          $display("FAIL rnd_rsp: valid %b id %0d data %h, required valid 1 id %0d data %h",
                   bus.rsp_valid, bus.rsp_id, bus.rsp_data, g, ref_inv(dv[g]));
        end
        bus.rsp_ready = (k == 7) || ($urandom_range(0, 2) == 0);
        tick();
        if (bus.rsp_ready) break;
      end
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d = rand128();
    logic [127:0] e = ref_inv(d);
    int n = 0, g;
    bus.rsp_ready = 1'b0;
    bus.req_data[{2'd1, 7'd0} +: 128] = d;
    bus.req_data[{2'd0, 7'd0} +: 128] = rand128();
    bus.req_data[{2'd2, 7'd0} +: 128] = rand128();
    bus.req_valid = 4'b0010;
    #1;
    while (bus.req_ready !== 4'b0010 && n < 50) begin tick(); n++; end
    tick();
    m_ptr = 1;
    bus.req_valid = 4'b0101;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 60) begin tick(); n++; end
    n_vec++;
    if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_timeout: rsp_valid %b required 1", bus.rsp_valid); end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e || bus.rsp_id !== 2'd1 || bus.req_ready !== 4'h0) begin
        n_err++;
        $display("FAIL bp_hold: valid %b id %0d data %h ready %b, required 1 1 %h 0000",
                 bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready, e);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release: busy %b rsp_valid %b required 0 0", bus.busy, bus.rsp_valid);
    end
    g = model_grant(4'b0101, m_ptr);
    n_vec++;
    if (bus.req_ready !== onehot(g)) begin
      n_err++; $display("FAIL bp_next_grant: req_ready %b required %b", bus.req_ready, onehot(g));
    end
    bus.req_valid = 4'h0;
    tick();
  endtask

  task automatic test_skip_pulse();
    logic [127:0] d = rand128();
    int n = 0, bad_grant = 0, spur = 0;
    bus.rsp_ready = 1'b1;
    bus.req_data[{2'd3, 7'd0} +: 128] = d;
    bus.req_valid = 4'b1000;
    #1;
    while (bus.req_ready !== 4'b1000 && n < 50) begin tick(); n++; end
    tick();
    m_ptr = 3;
    bus.req_valid = 4'b0010;
    repeat (6) begin
      #1;
      if (bus.req_ready !== 4'h0) bad_grant++;
      tick();
    end
    bus.req_valid = 4'h0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 60) begin tick(); n++; end
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_data !== ref_inv(d)) begin
      n_err++;
      $display("FAIL skip_rsp: valid %b id %0d data %h, required 1 3 %h",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, ref_inv(d));
    end
    tick();
    repeat (30) begin
      if (bus.rsp_valid === 1'b1) spur++;
      if (bus.req_ready !== 4'h0) bad_grant++;
      tick();
    end
    n_vec++;
    if (bad_grant != 0 || spur != 0) begin
      n_err++; $display("FAIL skip_pulse: grants %0d responses %0d, required 0 0", bad_grant, spur);
    end
  endtask

  task automatic test_reset_midop();
    logic [127:0] d = rand128();
    logic [127:0] got;
    int n = 0, spur = 0, gid, lat, g;
    bit ok;
    bus.rsp_ready = 1'b1;
    bus.req_data[{2'd2, 7'd0} +: 128] = d;
    bus.req_valid = 4'b0100;
    #1;
    while (bus.req_ready !== 4'b0100 && n < 50) begin tick(); n++; end
    tick();
    bus.req_valid = 4'h0;
    repeat (7) tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'h0) begin
      n_err++;
      $display("FAIL midop_reset: busy %b rsp_valid %b req_ready %b, required 0 0 0000",
               bus.busy, bus.rsp_valid, bus.req_ready);
    end
    rst = 1'b1;
    m_ptr = 3;
    repeat (20) begin
      tick();
      if (bus.rsp_valid === 1'b1) spur++;
    end
    n_vec++;
    if (spur != 0) begin n_err++; $display("FAIL midop_spurious: got %0d responses required 0", spur); end
    bus.req_valid = 4'b1001;
    #1;
    g = model_grant(4'b1001, m_ptr);
    n_vec++;
    if (bus.req_ready !== onehot(g)) begin
      n_err++; $display("FAIL midop_first_grant: req_ready %b required %b", bus.req_ready, onehot(g));
    end
    bus.req_valid = 4'h0;
    d = rand128();
    serve(0, d, got, gid, lat, ok);
    n_vec++;
    if (!ok || gid != 0 || got !== ref_inv(d) || lat != LAT) begin
      n_err++;
      $display("FAIL midop_fresh: ok %0d id %0d data %h lat %0d, required 1 0 %h %0d",
               ok, gid, got, lat, ref_inv(d), LAT);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    build_ref();
    test_reset();
    test_known_vector();
    test_const_blocks();
    test_round_robin();
    test_random_arb();
    test_backpressure();
    test_skip_pulse();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
